// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the parametrised UART core.
// State encodings for both serial FSMs plus divider and sizing functions.
package uart_pkg;

   localparam int OVS = 16;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

   function automatic int calc_div(input int clk_rate, input int baud_rate);
      return clk_rate / (baud_rate * OVS);
   endfunction

   function automatic int frame_len(input int data_bits, input int parity_en, input int stop_bits);
      return 1 + data_bits + parity_en + stop_bits;
   endfunction

   function automatic int fifo_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word fall-through FIFO with valid/ready on both sides.
// Head entry is visible on o_rd_data whenever o_rd_valid is high.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_wr_valid,
   output logic             o_wr_ready,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_rd_valid,
   input  logic             i_rd_ready
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = fifo_cnt_w(DEPTH);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_sync_fifo: DEPTH must be a power of two and at least 2");
   end

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_wr_ready = (r_count != CNT_W'(DEPTH));
   assign o_rd_valid = (r_count != '0);
   assign o_rd_data  = r_mem[r_rd_ptr];
   assign w_push     = i_wr_valid && o_wr_ready;
   assign w_pop      = i_rd_ready && o_rd_valid;

   // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
   end

endmodule

// File: rtl/uart_fifo_core.sv
// UART core: tick generator, TX/RX FSMs with configurable frame format,
// TX/RX FIFOs, sticky receive error flags and internal loopback.
module uart_fifo_core
   import uart_pkg::*;
#(
   parameter int CLK_RATE   = 100000000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   input  logic                 rx_in,
   output logic                 tx_out,
   input  logic                 loopback,
   input  logic                 err_clr,
   output logic                 tx_busy,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err,
   output logic                 rx_overrun
);

   localparam int   DIV         = calc_div(CLK_RATE, BAUD_RATE);
   localparam int   DIV_W       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int   OVS_W       = $clog2(OVS);
   localparam int   IDX_W       = $clog2(DATA_BITS);
   localparam logic PAR_ODD_BIT = (PARITY_ODD != 0);

   if (DIV < 1) begin : g_bad_div
      $error("uart_fifo_core: CLK_RATE/(BAUD_RATE*16) must be at least 1");
   end
   if ((DATA_BITS < 5) || (DATA_BITS > 8) || (STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_frame
      $error("uart_fifo_core: unsupported frame format");
   end

   // ---------------- oversample tick ----------------
   logic [DIV_W-1:0] r_div_cnt;
   logic             w_tick;

   assign w_tick = (r_div_cnt == DIV_W'(DIV - 1));

   always_ff @(posedge clk) begin
      if (rst)         r_div_cnt <= '0;
      else if (w_tick) r_div_cnt <= '0;
      else             r_div_cnt <= r_div_cnt + 1'b1;
   end

   // ---------------- transmitter ----------------
   logic [DATA_BITS-1:0] w_tx_head;
   logic                 w_tx_avail;
   logic                 w_tx_pop;
   logic                 w_tx_bit_end;
   logic                 w_tx_last_stop;

   tx_state_t            r_tx_state;
   logic [DATA_BITS-1:0] r_tx_shift;
   logic                 r_tx_par;
   logic                 r_tx_line;
   logic                 r_tx_busy;
   logic                 r_tx_started;
   logic [OVS_W-1:0]     r_tx_ovs;
   logic [IDX_W-1:0]     r_tx_idx;
   logic                 r_tx_stop_idx;

   uart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_wr_data  (tx_data),
      .i_wr_valid (tx_valid),
      .o_wr_ready (tx_ready),
      .o_rd_data  (w_tx_head),
      .o_rd_valid (w_tx_avail),
      .i_rd_ready (w_tx_pop)
   );

   assign w_tx_bit_end   = w_tick && r_tx_started && (r_tx_ovs == OVS_W'(OVS - 1));
   assign w_tx_last_stop = (r_tx_stop_idx == 1'(STOP_BITS - 1));
   assign w_tx_pop       = w_tx_avail &&
                           ((r_tx_state == TX_IDLE) ||
                            ((r_tx_state == TX_STOP) && w_tx_bit_end && w_tx_last_stop));

   // r_tx_started separates "frame loaded" from "start bit on the line", so
   // the first start bit is aligned to a tick boundary.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_state    <= TX_IDLE;
         r_tx_shift    <= '0;
         r_tx_par      <= 1'b0;
         r_tx_line     <= 1'b1;
         r_tx_busy     <= 1'b0;
         r_tx_started  <= 1'b0;
         r_tx_ovs      <= '0;
         r_tx_idx      <= '0;
         r_tx_stop_idx <= 1'b0;
      end else begin
         if (w_tick && r_tx_started) r_tx_ovs <= r_tx_ovs + 1'b1;
         case (r_tx_state)
            TX_IDLE: begin
               if (w_tx_avail) begin
                  r_tx_shift   <= w_tx_head;
                  r_tx_par     <= (^w_tx_head) ^ PAR_ODD_BIT;
                  r_tx_busy    <= 1'b1;
                  r_tx_started <= 1'b0;
                  r_tx_ovs     <= '0;
                  r_tx_state   <= TX_START;
               end
            end
            TX_START: begin
               if (w_tick && !r_tx_started) begin
                  r_tx_started <= 1'b1;
                  r_tx_line    <= 1'b0;
               end else if (w_tx_bit_end) begin
                  r_tx_line  <= r_tx_shift[0];
                  r_tx_shift <= r_tx_shift >> 1;
                  r_tx_idx   <= '0;
                  r_tx_state <= TX_DATA;
               end
            end
            TX_DATA: begin
               if (w_tx_bit_end) begin
                  if (r_tx_idx == IDX_W'(DATA_BITS - 1)) begin
                     if (PARITY_EN != 0) begin
                        r_tx_line  <= r_tx_par;
                        r_tx_state <= TX_PARITY;
                     end else begin
                        r_tx_line     <= 1'b1;
                        r_tx_stop_idx <= 1'b0;
                        r_tx_state    <= TX_STOP;
                     end
                  end else begin
                     r_tx_line  <= r_tx_shift[0];
                     r_tx_shift <= r_tx_shift >> 1;
                     r_tx_idx   <= r_tx_idx + 1'b1;
                  end
               end
            end
            TX_PARITY: begin
               if (w_tx_bit_end) begin
                  r_tx_line     <= 1'b1;
                  r_tx_stop_idx <= 1'b0;
                  r_tx_state    <= TX_STOP;
               end
            end
            TX_STOP: begin
               if (w_tx_bit_end) begin
                  if (!w_tx_last_stop) begin
                     r_tx_stop_idx <= r_tx_stop_idx + 1'b1;
                  end else if (w_tx_avail) begin
                     r_tx_shift <= w_tx_head;
                     r_tx_par   <= (^w_tx_head) ^ PAR_ODD_BIT;
                     r_tx_line  <= 1'b0;
                     r_tx_state <= TX_START;
                  end else begin
                     r_tx_busy    <= 1'b0;
                     r_tx_started <= 1'b0;
                     r_tx_state   <= TX_IDLE;
                  end
               end
            end
            default: r_tx_state <= TX_IDLE;
         endcase
      end
   end

   assign tx_out  = loopback ? 1'b1 : r_tx_line;
   assign tx_busy = r_tx_busy;

   // ---------------- receiver ----------------
   logic                 w_rx_src;
   logic                 w_rx_sample;
   logic                 w_rx_start_sample;
   logic                 w_rx_stop_eval;
   logic                 w_rx_stop_bad;
   logic                 w_rx_par_bad;
   logic                 w_rx_frame_ok;
   logic                 w_rx_push;
   logic                 w_rx_fifo_ready;

   logic                 r_rx_sync1;
   logic                 r_rx_sync2;
   rx_state_t            r_rx_state;
   logic [OVS_W-1:0]     r_rx_ovs;
   logic [IDX_W-1:0]     r_rx_idx;
   logic [DATA_BITS-1:0] r_rx_shift;
   logic                 r_rx_par_bit;
   logic                 r_frame_err;
   logic                 r_parity_err;
   logic                 r_overrun;

   assign w_rx_src = loopback ? r_tx_line : rx_in;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_sync1 <= 1'b1;
         r_rx_sync2 <= 1'b1;
      end else begin
         r_rx_sync1 <= w_rx_src;
         r_rx_sync2 <= r_rx_sync1;
      end
   end

   assign w_rx_sample       = w_tick && (r_rx_ovs == OVS_W'(OVS - 1));
   assign w_rx_start_sample = w_tick && (r_rx_ovs == OVS_W'(OVS / 2 - 1));
   assign w_rx_stop_eval    = (r_rx_state == RX_STOP) && w_rx_sample;
   assign w_rx_stop_bad     = !r_rx_sync2;
   assign w_rx_par_bad      = (PARITY_EN != 0) &&
                              (r_rx_par_bit != ((^r_rx_shift) ^ PAR_ODD_BIT));
   assign w_rx_frame_ok     = w_rx_stop_eval && !w_rx_stop_bad && !w_rx_par_bad;
   assign w_rx_push         = w_rx_frame_ok && w_rx_fifo_ready;

   // Oversample count runs from the arming edge; start is checked mid-bit,
   // then every bit is sampled one full bit period after the previous one.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_state   <= RX_IDLE;
         r_rx_ovs     <= '0;
         r_rx_idx     <= '0;
         r_rx_shift   <= '0;
         r_rx_par_bit <= 1'b0;
      end else begin
         if (w_tick && (r_rx_state != RX_IDLE)) r_rx_ovs <= r_rx_ovs + 1'b1;
         case (r_rx_state)
            RX_IDLE: begin
               if (!r_rx_sync2) begin
                  r_rx_ovs   <= '0;
                  r_rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (w_rx_start_sample) begin
                  r_rx_ovs <= '0;
                  r_rx_idx <= '0;
                  r_rx_state <= r_rx_sync2 ? RX_IDLE : RX_DATA;
               end
            end
            RX_DATA: begin
               if (w_rx_sample) begin
                  r_rx_shift <= {r_rx_sync2, r_rx_shift[DATA_BITS-1:1]};
                  if (r_rx_idx == IDX_W'(DATA_BITS - 1)) begin
                     r_rx_state <= (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
                  end else begin
                     r_rx_idx <= r_rx_idx + 1'b1;
                  end
               end
            end
            RX_PARITY: begin
               if (w_rx_sample) begin
                  r_rx_par_bit <= r_rx_sync2;
                  r_rx_state   <= RX_STOP;
               end
            end
            RX_STOP: begin
               if (w_rx_sample) r_rx_state <= RX_IDLE;
            end
            default: r_rx_state <= RX_IDLE;
         endcase
      end
   end

   // Setting an error takes priority over a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_err  <= 1'b0;
         r_parity_err <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         if (w_rx_stop_eval && w_rx_stop_bad)                r_frame_err <= 1'b1;
         else if (err_clr)                                   r_frame_err <= 1'b0;
         if (w_rx_stop_eval && w_rx_par_bad)                 r_parity_err <= 1'b1;
         else if (err_clr)                                   r_parity_err <= 1'b0;
         if (w_rx_frame_ok && !w_rx_fifo_ready)              r_overrun <= 1'b1;
         else if (err_clr)                                   r_overrun <= 1'b0;
      end
   end

   uart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_rx_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_wr_data  (r_rx_shift),
      .i_wr_valid (w_rx_push),
      .o_wr_ready (w_rx_fifo_ready),
      .o_rd_data  (rx_data),
      .o_rd_valid (rx_valid),
      .i_rd_ready (rx_ready)
   );

   assign rx_frame_err  = r_frame_err;
   assign rx_parity_err = r_parity_err;
   assign rx_overrun    = r_overrun;

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench: 8N1 core for loopback/FIFO/error/reset cases, plus 7E1 and
// 7O1 cores whose serial frames are checked against a hand-computed table.
module tb_uart_fifo_core;

   localparam int CLK_RATE  = 1600000;
   localparam int BAUD_RATE = 10000;
   localparam int BIT_CLKS  = 160;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid, tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid, rx_ready, rx_in, tx_out, loopback, err_clr, tx_busy;
   logic       rx_frame_err, rx_parity_err, rx_overrun;

   logic [6:0] tx_data7;
   logic       tx_valid7;
   logic       tx_ready_e, rx_valid_e, tx_out_e, tx_busy_e, fe_e, pe_e, ov_e;
   logic       tx_ready_o, rx_valid_o, tx_out_o, tx_busy_o, fe_o, pe_o, ov_o;
   logic [6:0] rx_data_e, rx_data_o;

   uart_fifo_core #(
      .CLK_RATE(CLK_RATE), .BAUD_RATE(BAUD_RATE), .DATA_BITS(8),
      .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(8)
   ) u_dut (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_in(rx_in),
      .tx_out(tx_out), .loopback(loopback), .err_clr(err_clr), .tx_busy(tx_busy),
      .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err), .rx_overrun(rx_overrun)
   );

   uart_fifo_core #(
      .CLK_RATE(CLK_RATE), .BAUD_RATE(BAUD_RATE), .DATA_BITS(7),
      .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(8)
   ) u_dut_e (
      .clk(clk), .rst(rst), .tx_data(tx_data7), .tx_valid(tx_valid7), .tx_ready(tx_ready_e),
      .rx_data(rx_data_e), .rx_valid(rx_valid_e), .rx_ready(1'b0), .rx_in(1'b1),
      .tx_out(tx_out_e), .loopback(1'b0), .err_clr(1'b0), .tx_busy(tx_busy_e),
      .rx_frame_err(fe_e), .rx_parity_err(pe_e), .rx_overrun(ov_e)
   );

   uart_fifo_core #(
      .CLK_RATE(CLK_RATE), .BAUD_RATE(BAUD_RATE), .DATA_BITS(7),
      .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1), .FIFO_DEPTH(8)
   ) u_dut_o (
      .clk(clk), .rst(rst), .tx_data(tx_data7), .tx_valid(tx_valid7), .tx_ready(tx_ready_o),
      .rx_data(rx_data_o), .rx_valid(rx_valid_o), .rx_ready(1'b0), .rx_in(1'b1),
      .tx_out(tx_out_o), .loopback(1'b0), .err_clr(1'b0), .tx_busy(tx_busy_o),
      .rx_frame_err(fe_o), .rx_parity_err(pe_o), .rx_overrun(ov_o)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_cmp++;
      if ((act < lo) || (act > hi)) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   task automatic clocks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pop_rx();
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic pulse_err_clr();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      @(negedge clk);
   endtask

   // Drives one 8-bit frame on rx_in; stop bit value and length selectable.
   task automatic send_rx(input logic [7:0] b, input logic stop_val, input int stop_len);
      rx_in = 1'b0;
      clocks(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         rx_in = b[i];
         clocks(BIT_CLKS);
      end
      rx_in = stop_val;
      clocks(stop_len);
      rx_in = 1'b1;
   endtask

   typedef struct {
      logic [6:0] data;
      logic [9:0] exp_even;
      logic [9:0] exp_odd;
   } par_vec_t;

   par_vec_t vecs [5];

   initial begin
      logic [9:0] cap_e, cap_o, cap;
      logic [7:0] b;
      int         busy_cnt, rx_at, accepted, glitches;
      logic       tx_low_seen, found;

      // frame bit i = line value in bit slot i: {stop, parity, d6..d0, start}
      vecs[0] = '{7'h35, 10'b1_0_0110101_0, 10'b1_1_0110101_0};
      vecs[1] = '{7'h7F, 10'b1_1_1111111_0, 10'b1_0_1111111_0};
      vecs[2] = '{7'h00, 10'b1_0_0000000_0, 10'b1_1_0000000_0};
      vecs[3] = '{7'h41, 10'b1_0_1000001_0, 10'b1_1_1000001_0};
      vecs[4] = '{7'h2A, 10'b1_1_0101010_0, 10'b1_0_0101010_0};

      rst = 1'b1; tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; rx_in = 1'b1;
      loopback = 1'b1; err_clr = 1'b0; tx_data7 = '0; tx_valid7 = 1'b0;
      clocks(3);
      rst = 1'b0;
      @(negedge clk);

      check("reset_tx_out",   tx_out, 1'b1);
      check("reset_tx_busy",  tx_busy, 1'b0);
      check("reset_tx_ready", tx_ready, 1'b1);
      check("reset_rx_valid", rx_valid, 1'b0);
      check("reset_errs",     {rx_frame_err, rx_parity_err, rx_overrun}, 3'b000);

      // ---- parity frames on the 7E1 / 7O1 cores ----
      for (int v = 0; v < 5; v++) begin
         tx_data7 = vecs[v].data; tx_valid7 = 1'b1;
         @(negedge clk);
         tx_valid7 = 1'b0;
         found = 1'b0;
         for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (tx_out_e == 1'b0) found = 1'b1;
         end
         check($sformatf("par%0d_start_seen", v), found, 1'b1);
         clocks(BIT_CLKS / 2);
         cap_e[0] = tx_out_e; cap_o[0] = tx_out_o;
         for (int k = 1; k < 10; k++) begin
            clocks(BIT_CLKS);
            cap_e[k] = tx_out_e; cap_o[k] = tx_out_o;
         end
         check($sformatf("par%0d_even_frame d=%0h", v, vecs[v].data), cap_e, vecs[v].exp_even);
         check($sformatf("par%0d_odd_frame d=%0h", v, vecs[v].data), cap_o, vecs[v].exp_odd);
         clocks(BIT_CLKS);
      end
      check("par_busy_idle", {tx_busy_e, tx_busy_o, tx_ready_e, tx_ready_o}, 4'b0011);
      check("par_rx_quiet", {rx_valid_e, rx_valid_o, fe_e, pe_e, ov_e, fe_o, pe_o, ov_o}, 8'h00);

      // ---- loopback single frame 0xA5 ----
      tx_data = 8'hA5; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      busy_cnt = 0; rx_at = -1; tx_low_seen = 1'b0;
      for (int i = 0; i < 2500; i++) begin
         @(negedge clk);
         if (tx_out !== 1'b1) tx_low_seen = 1'b1;
         if (tx_busy) busy_cnt++;
         if (rx_valid && (rx_at < 0)) rx_at = i;
      end
      check("lb_tx_out_held_high", tx_low_seen, 1'b0);
      check_range("lb_busy_cycles", busy_cnt, 1600, 1612);
      check_range("lb_rx_latency", rx_at, 1400, 1700);
      check("lb_rx_data", rx_data, 8'hA5);
      pop_rx();
      check("lb_rx_empty_after_pop", rx_valid, 1'b0);

      // ---- overrun: 9 looped frames into an 8-deep RX FIFO ----
      for (int i = 0; i < 9; i++) begin
         tx_data = 8'hC0 + 8'(i); tx_valid = 1'b1;
         @(negedge clk);
      end
      tx_valid = 1'b0;
      clocks(9 * 1600 + 400);
      check("ovr_tx_idle", tx_busy, 1'b0);
      check("ovr_flags", {rx_overrun, rx_frame_err, rx_parity_err}, 3'b100);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("ovr_pop%0d", i), {rx_valid, rx_data}, {1'b1, 8'hC0 + 8'(i)});
         pop_rx();
      end
      check("ovr_rx_empty", rx_valid, 1'b0);
      pulse_err_clr();
      check("ovr_cleared", rx_overrun, 1'b0);

      // ---- back-to-back burst: 12 offered, 9 accepted ----
      loopback = 1'b0;
      clocks(2);
      accepted = 0;
      for (int i = 0; i < 12; i++) begin
         tx_data = 8'h10 + 8'(i); tx_valid = 1'b1;
         if (tx_ready) accepted++;
         @(negedge clk);
      end
      tx_valid = 1'b0;
      check("burst_accepted", accepted, 9);
      check("burst_tx_ready_low", tx_ready, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         if (tx_out == 1'b0) found = 1'b1;
         else @(negedge clk);
      end
      check("burst_start_seen", found, 1'b1);
      clocks(BIT_CLKS / 2);
      for (int f = 0; f < 9; f++) begin
         for (int k = 0; k < 10; k++) begin
            cap[k] = tx_out;
            clocks(BIT_CLKS);
         end
         b = 8'h10 + 8'(f);
         check($sformatf("burst_frame%0d", f), cap, {1'b1, b, 1'b0});
      end
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         @(negedge clk);
         if (!tx_busy) found = 1'b1;
      end
      check("burst_done", {found, tx_ready}, 2'b11);

      // ---- external RX: framing error, false start, clean frame ----
      send_rx(8'h3C, 1'b0, 100);
      clocks(600);
      check("rxerr_flags", {rx_frame_err, rx_parity_err, rx_overrun}, 3'b100);
      check("rxerr_no_push", rx_valid, 1'b0);
      pulse_err_clr();
      check("rxerr_cleared", rx_frame_err, 1'b0);
      rx_in = 1'b0;
      clocks(40);
      rx_in = 1'b1;
      clocks(400);
      check("false_start_quiet", {rx_valid, rx_frame_err, rx_parity_err, rx_overrun}, 4'b0000);
      send_rx(8'h3C, 1'b1, BIT_CLKS);
      clocks(400);
      check("rx_clean_frame", {rx_valid, rx_data, rx_frame_err}, {1'b1, 8'h3C, 1'b0});
      pop_rx();

      // ---- reset mid-frame with 3 bytes queued ----
      for (int i = 0; i < 3; i++) begin
         tx_data = (i == 0) ? 8'h81 : 8'h42 + 8'(i); tx_valid = 1'b1;
         @(negedge clk);
      end
      tx_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         @(negedge clk);
         if (tx_out == 1'b0) found = 1'b1;
      end
      check("rst_start_seen", found, 1'b1);
      clocks(BIT_CLKS / 2 + 4 * BIT_CLKS);
      check("rst_mid_d3", {tx_busy, tx_out}, 2'b10);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_outputs", {tx_out, tx_busy, tx_ready, rx_valid}, 4'b1010);
      glitches = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (!tx_out || tx_busy || rx_valid || !tx_ready) glitches++;
      end
      check("rst_fifos_empty", glitches, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
